// File: rtl/add_sub_serial_nbit_if.sv
// rtl/add_sub_serial_nbit_if.sv - operand/result handshake bundle for the serial adder/subtractor
interface add_sub_serial_nbit_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         add_n;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, x, y, add_n, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, x, y, add_n, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/add_sub_serial_nbit.sv
// rtl/add_sub_serial_nbit.sv - N-bit add/sub computed W bits per clock through one slice
// Carry lives in a register between slices; result held in DONE until the consumer takes it.
module add_sub_serial_nbit #(
  parameter int N = 32,
  parameter int W = 8
) (
  input logic                 clk,
  input logic                 rst,
  add_sub_serial_nbit_if.slave bus_if
);
  localparam int NCHUNK = N / W;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_bad_params
    $error("add_sub_serial_nbit: N must be a positive multiple of W");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  xa_q, xa_d;
  logic [N-1:0]  yb_q, yb_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [W-1:0]  xs, ys;
  logic [W:0]    slice;
  logic          last;

  // Select the active chunk with constant part-selects so no variable index reaches synthesis.
  always_comb begin
    xs = '0;
    ys = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt_q == CW'(k)) begin
        xs = xa_q[k*W +: W];
        ys = yb_q[k*W +: W];
      end
    end
    slice = {1'b0, xs} + {1'b0, ys} + {{W{1'b0}}, carry_q};
    last  = (cnt_q == CW'(NCHUNK - 1));
  end

  always_comb begin
    state_d          = state_q;
    xa_d             = xa_q;
    yb_d             = yb_q;
    carry_d          = carry_q;
    cnt_d            = cnt_q;
    sum_d            = sum_q;
    cout_d           = cout_q;
    ovf_d            = ovf_q;
    bus_if.in_ready  = 1'b0;
    bus_if.out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus_if.in_ready = 1'b1;
        if (bus_if.in_valid) begin
          xa_d    = bus_if.x;
          yb_d    = bus_if.add_n ? ~bus_if.y : bus_if.y;
          carry_d = bus_if.add_n;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < NCHUNK; k++) begin
          if (cnt_q == CW'(k)) begin
            sum_d[k*W +: W] = slice[W-1:0];
          end
        end
        carry_d = slice[W];
        if (last) begin
          cout_d  = slice[W];
          ovf_d   = (xa_q[N-1] == yb_q[N-1]) && (slice[W-1] != xa_q[N-1]);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        bus_if.out_valid = 1'b1;
        if (bus_if.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      xa_q    <= '0;
      yb_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      xa_q    <= xa_d;
      yb_q    <= yb_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus_if.sum  = sum_q;
  assign bus_if.cout = cout_q;
  assign bus_if.ovf  = ovf_q;
endmodule

// File: tb/tb_add_sub_serial_nbit.sv
// tb/tb_add_sub_serial_nbit.sv - self-checking bench for add_sub_serial_nbit at three geometries
module tb_add_sub_serial_nbit;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  add_sub_serial_nbit_if #(.N(32)) b32 ();
  add_sub_serial_nbit_if #(.N(16)) b16 ();
  add_sub_serial_nbit_if #(.N(64)) b64 ();

  add_sub_serial_nbit #(.N(32), .W(8))  u32 (.clk(clk), .rst(rst), .bus_if(b32.slave));
  add_sub_serial_nbit #(.N(16), .W(16)) u16 (.clk(clk), .rst(rst), .bus_if(b16.slave));
  add_sub_serial_nbit #(.N(64), .W(1))  u64 (.clk(clk), .rst(rst), .bus_if(b64.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Signed/unsigned arithmetic on wide integers, no slicing or carry chains.
  function automatic void model(input int n, input logic [63:0] a, input logic [63:0] b,
                                input logic m, output logic [63:0] s, output logic c,
                                output logic o);
    logic [65:0]        mask, wa, wb, r;
    logic signed [65:0] sa, sb, sr, maxv, minv;
    mask = (66'd1 << n) - 66'd1;
    wa   = {2'b00, a} & mask;
    wb   = {2'b00, b} & mask;
    r    = m ? (wa - wb) : (wa + wb);
    s    = r[63:0] & mask[63:0];
    c    = m ? (wa >= wb) : r[n];
    sa   = signed'(wa[n-1] ? (wa | ~mask) : wa);
    sb   = signed'(wb[n-1] ? (wb | ~mask) : wb);
    sr   = m ? (sa - sb) : (sa + sb);
    maxv = signed'((66'd1 << (n - 1)) - 66'd1);
    minv = -maxv - 66'sd1;
    o    = (sr > maxv) || (sr < minv);
  endfunction

  task automatic expect_op(input string tag, input int n, input logic [63:0] a,
                           input logic [63:0] b, input logic m, input logic [63:0] gs,
                           input logic gc, input logic go, input int lat, input int explat);
    logic [63:0] es;
    logic        ec, eo;
    model(n, a, b, m, es, ec, eo);
    check({tag, ".sum"}, gs, es);
    check({tag, ".cout"}, {63'd0, gc}, {63'd0, ec});
    check({tag, ".ovf"}, {63'd0, go}, {63'd0, eo});
    check({tag, ".lat"}, 64'(lat), 64'(explat));
  endtask

  task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic m, output int lat);
    b32.x = a; b32.y = b; b32.add_n = m; b32.in_valid = 1'b1;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    lat = 0;
    while (!b32.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release32();
    b32.out_ready = 1'b1;
    @(posedge clk); #1;
    b32.out_ready = 1'b0;
  endtask

  task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b, input logic m);
    int lat;
    start32(a, b, m, lat);
    expect_op(tag, 32, {32'd0, a}, {32'd0, b}, m, {32'd0, b32.sum}, b32.cout, b32.ovf, lat, 4);
    release32();
    check({tag, ".in_ready"}, {63'd0, b32.in_ready}, 64'd1);
  endtask

  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b, input logic m);
    int lat;
    b16.x = a; b16.y = b; b16.add_n = m; b16.in_valid = 1'b1;
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
    lat = 0;
    while (!b16.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    expect_op(tag, 16, {48'd0, a}, {48'd0, b}, m, {48'd0, b16.sum}, b16.cout, b16.ovf, lat, 1);
    b16.out_ready = 1'b1;
    @(posedge clk); #1;
    b16.out_ready = 1'b0;
  endtask

  task automatic op64(input string tag, input logic [63:0] a, input logic [63:0] b, input logic m);
    int lat;
    b64.x = a; b64.y = b; b64.add_n = m; b64.in_valid = 1'b1;
    @(posedge clk); #1;
    b64.in_valid = 1'b0;
    lat = 0;
    while (!b64.out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    expect_op(tag, 64, a, b, m, b64.sum, b64.cout, b64.ovf, lat, 64);
    b64.out_ready = 1'b1;
    @(posedge clk); #1;
    b64.out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] held;
    logic [63:0] es;
    logic        ec, eo;

    errors = 0; checks = 0;
    clk = 1'b0; rst = 1'b1;
    b32.in_valid = 0; b32.x = '0; b32.y = '0; b32.add_n = 0; b32.out_ready = 0;
    b16.in_valid = 0; b16.x = '0; b16.y = '0; b16.add_n = 0; b16.out_ready = 0;
    b64.in_valid = 0; b64.x = '0; b64.y = '0; b64.add_n = 0; b64.out_ready = 0;

    #12;
    check("rst.in_ready", {63'd0, b32.in_ready}, 64'd1);
    check("rst.out_valid", {63'd0, b32.out_valid}, 64'd0);
    check("rst.sum", {32'd0, b32.sum}, 64'd0);
    check("rst.cout", {63'd0, b32.cout}, 64'd0);
    check("rst.ovf", {63'd0, b32.ovf}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    op32("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    op32("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1);
    op32("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    op32("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1);
    op32("sub_zero", 32'h0000_0000, 32'h0000_0000, 1'b1);

    // Hold the result under backpressure while the source wiggles its inputs.
    start32(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, lat);
    held = b32.sum;
    model(32, 64'h1234_5678, 64'h0F0F_0F0F, 1'b0, es, ec, eo);
    check("bp.sum", {32'd0, held}, es);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      b32.x = $urandom; b32.y = $urandom; b32.in_valid = 1'($urandom_range(0, 1));
      check("bp.out_valid", {63'd0, b32.out_valid}, 64'd1);
      check("bp.hold", {32'd0, b32.sum}, {32'd0, held});
      check("bp.in_ready", {63'd0, b32.in_ready}, 64'd0);
    end
    b32.in_valid = 1'b0;
    release32();
    check("bp.release_ready", {63'd0, b32.in_ready}, 64'd1);
    check("bp.release_valid", {63'd0, b32.out_valid}, 64'd0);

    // Abort two cycles into a run.
    b32.x = 32'h1122_3344; b32.y = 32'h0101_0101; b32.add_n = 1'b0; b32.in_valid = 1'b1;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort.out_valid", {63'd0, b32.out_valid}, 64'd0);
    check("abort.sum", {32'd0, b32.sum}, 64'd0);
    check("abort.in_ready", {63'd0, b32.in_ready}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    op32("after_abort", 32'd3, 32'd4, 1'b0);

    for (int i = 0; i < 8; i++) begin
      op32("rand32", $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    op16("w16_ovf", 16'h8000, 16'h8000, 1'b0);
    op16("w16_sub", 16'h0003, 16'h8001, 1'b1);

    op64("w1_add", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      op64("rand64", {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/add_sub_serial_nbit.md
Name: add_sub_serial_nbit

Overview:
- Multi-cycle N-bit adder/subtractor. Processes operands W bits per clock through one W-bit slice, with the carry held in a register between cycles.
- Generalises the combinational n-bit add/sub to any width at fixed slice cost. Adds a valid/ready handshake on input and output, plus a signed-overflow flag.
- Used where wide add/sub (32..256 bits) must share a narrow datapath in timing- or area-limited paths.

Parameters:
- N, 32, total operand/result width; must be a multiple of W (elaboration error otherwise).
- W, 8, slice width processed per cycle; 1 <= W <= N.
- NCHUNK, N/W, derived local constant: number of slice cycles.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and mode present.
- in_ready  output  1  block can accept an operation.
- x  input  N  operand A.
- y  input  N  operand B.
- add_n  input  1  0 = add (x+y), 1 = subtract (x-y).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- sum  output  N  result, modulo 2^N.
- cout  output  1  carry out of bit N-1; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, internal operand/carry/count registers=0.
- State IDLE:
  - in_ready=1.
  - On in_valid at a clk edge, the block registers xa=x and yb=(add_n ? ~y : y), sets carry=add_n and cnt=0, then moves to RUN.
- State RUN:
  - in_ready=0.
  - Each cycle: {c,s} = xa[cnt*W +: W] + yb[cnt*W +: W] + carry. s is written to sum[cnt*W +: W], carry<=c, cnt<=cnt+1.
  - On the cycle with cnt==NCHUNK-1, the block also registers cout=c and ovf=(xa[N-1]==yb[N-1]) && (s[W-1]!=xa[N-1]), then moves to DONE.
- State DONE:
  - out_valid=1, in_ready=0.
  - sum, cout and ovf are held stable.
  - On out_ready at a clk edge, the block moves to IDLE and out_valid=0 next cycle.
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge. With N==W, out_valid rises 1 cycle after acceptance.
- Throughput: one operation per NCHUNK+2 cycles minimum. No overlap between the output and a new acceptance.
- x, y and add_n are sampled only at acceptance. Changes during RUN/DONE have no effect.
- in_valid while not in IDLE is ignored. No operation is queued; the source must hold in_valid until in_ready.
- Partially written sum bits may be visible during RUN. They are valid only while out_valid=1.
- rst asserted in any state aborts the operation: outputs return to reset values immediately and no result is produced.
- Arithmetic: the result is exact modulo 2^N. Subtract is computed as x + ~y + 1. 0 - 0 gives sum=0, cout=1, ovf=0.
- Counter width: clog2(NCHUNK), minimum 1 bit. cnt does not wrap during RUN.

Test Plan:
- N=32, W=8, add 0xFFFFFFFF + 0x00000001 -> sum=0x00000000, cout=1, ovf=0; out_valid high exactly 4 cycles after acceptance.
- N=32, W=8, sub 0x00000005 - 0x00000007 -> sum=0xFFFFFFFE, cout=0, ovf=0.
- N=32, W=8, add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, ovf=1, cout=0. Then sub 0x80000000 - 0x00000001 -> sum=0x7FFFFFFF, ovf=1, cout=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE and toggle x/y/in_valid -> out_valid stays 1, sum stable, in_ready=0. On out_ready=1, in_ready=1 next cycle.
- Reset mid-RUN: assert rst 2 cycles after acceptance -> out_valid=0, sum=0, in_ready=1 immediately. A fresh add 3+4 then yields 7 after 4 cycles.
- Parameter sweep: N=16, W=16 gives latency 1, 0x8000 + 0x8000 -> sum=0x0000, cout=1, ovf=1. N=64, W=1 gives latency 64; random add/sub checked against a reference model.
